// File: rtl/wino_tile_gen_if.sv
// Pixel-stream in / 4x4 tile-stream out bundle for the Winograd tile generator.
interface wino_tile_gen_if #(
  parameter int unsigned WI = 8
);
  logic               pix_valid;
  logic               pix_sof;
  logic [WI-1:0]      pix_in;
  logic               tile_valid;
  logic [16*WI-1:0]   data;
  logic [7:0]         tile_row;
  logic [7:0]         tile_col;
  logic               frame_done;

  modport master (
    output pix_valid, pix_sof, pix_in,
    input  tile_valid, data, tile_row, tile_col, frame_done
  );

  modport slave (
    input  pix_valid, pix_sof, pix_in,
    output tile_valid, data, tile_row, tile_col, frame_done
  );
endinterface

// File: rtl/wino_tile_gen.sv
// Builds overlapping 4x4 tiles (stride 2) from a raster pixel stream using
// four rotating line buffers and a sliding 4x4 window.
module wino_tile_gen #(
  parameter int unsigned WI    = 8,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic            clk,
  input  logic            rstn,
  wino_tile_gen_if.slave  bus
);
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned DW = 16 * WI;

  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [WI-1:0]   r_lb  [4][IMG_W];
  logic [WI-1:0]   r_win [4][4];
  logic            r_tile_valid;
  logic            r_frame_done;
  logic [DW-1:0]   r_data;
  logic [7:0]      r_tile_row;
  logic [7:0]      r_tile_col;

  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  logic [CW-1:0]   w_col_nxt;
  logic [RW-1:0]   w_row_nxt;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_emit;
  logic            w_last;
  logic [1:0]      w_lsel [3];
  logic [WI-1:0]   w_win  [4][4];
  logic [DW-1:0]   w_data;

  // Position of the incoming pixel; start-of-frame forces (0,0).
  always_comb begin
    w_col      = bus.pix_sof ? '0 : r_col;
    w_row      = bus.pix_sof ? '0 : r_row;
    w_last_col = (w_col == CW'(IMG_W - 1));
    w_last_row = (w_row == RW'(IMG_H - 1));
    w_col_nxt  = w_last_col ? '0 : w_col + CW'(1);
    w_row_nxt  = w_row;
    if (w_last_col) begin
      w_row_nxt = w_last_row ? '0 : w_row + RW'(1);
    end
    w_emit = (w_row >= RW'(3)) && (w_col >= CW'(3)) && w_row[0] && w_col[0];
    w_last = w_last_row && w_last_col;
  end

  // Rows row-3, row-2, row-1 live in line buffers (row+1, row+2, row+3) mod 4.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_lsel[r] = w_row[1:0] + 2'(r + 1);
    end
  end

  // Next window: shift left one column, new right column from line buffers + bypassed pixel.
  always_comb begin
    w_win = r_win;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_win[r][c] = r_win[r][c+1];
      end
    end
    for (int r = 0; r < 3; r++) begin
      w_win[r][3] = r_lb[w_lsel[r]][w_col];
    end
    w_win[3][3] = bus.pix_in;
  end

  always_comb begin
    w_data = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_data[(4*r+c)*WI +: WI] = w_win[r][c];
      end
    end
  end

  // Line buffers carry no reset; stale rows are never read before being rewritten.
  always_ff @(posedge clk) begin
    if (rstn && bus.pix_valid) begin
      r_lb[w_row[1:0]][w_col] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_col        <= '0;
      r_row        <= '0;
      r_tile_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_data       <= '0;
      r_tile_row   <= '0;
      r_tile_col   <= '0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_tile_valid <= bus.pix_valid && w_emit;
      r_frame_done <= bus.pix_valid && w_last;
      if (bus.pix_valid) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        r_win <= w_win;
        if (w_emit) begin
          r_data     <= w_data;
          r_tile_row <= 8'((w_row - RW'(3)) >> 1);
          r_tile_col <= 8'((w_col - CW'(3)) >> 1);
        end
      end
    end
  end

  assign bus.tile_valid = r_tile_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.data       = r_data;
  assign bus.tile_row   = r_tile_row;
  assign bus.tile_col   = r_tile_col;

endmodule

// File: doc/wino_tile_gen.md
WINO_TILE_GEN -- requirements
Module: wino_tile_gen

Parameters
REQ-001 WI, default 8, pixel width in bits; matches the data width of wino_kern_top.
REQ-002 IMG_W, default 8, frame width in pixels; SHALL be even and >= 4.
REQ-003 IMG_H, default 8, frame height in pixels; SHALL be even and >= 4.

Interface
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 pix_valid  input  1  pix_in carries a valid pixel this cycle.
REQ-007 pix_sof  input  1  qualified by pix_valid; marks pixel (0,0) of a frame.
REQ-008 pix_in  input  WI  raster-order pixel, unsigned.
REQ-009 tile_valid  output  1  data holds a complete 4x4 tile this cycle (one-cycle pulse).
REQ-010 data  output  16*WI  tile d[r][c] at bits [(4r+c)*WI +: WI], r,c in 0..3; connects directly to wino_kern_top.data.
REQ-011 tile_row  output  8  tile row index i (top-left pixel row = 2i).
REQ-012 tile_col  output  8  tile column index j (top-left pixel column = 2j).
REQ-013 frame_done  output  1  one-cycle pulse, registered together with the last pixel of a frame.

Function
REQ-014 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1); it SHALL advance them only on cycles where pix_valid is high; col wraps to 0 and row increments; after (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-015 pix_valid with pix_sof SHALL treat the pixel as (0,0) regardless of counter state; the counters then continue from (0,1); this resyncs after a truncated frame.
REQ-016 Storage: 4 line buffers of IMG_W x WI, selected by row mod 4; each valid pixel SHALL be written to lb[row mod 4][col].
REQ-017 Window: 4x4 register array; on each valid pixel, columns shift toward c=0, and new column c=3 SHALL load {lb[(row-3)mod4][col], lb[(row-2)mod4][col], lb[(row-1)mod4][col], pix_in} as r=0..3. The new pixel SHALL bypass the line-buffer write (no read-after-write hazard).
REQ-018 Emission: when a valid pixel has row>=3, col>=3, row odd and col odd, the block SHALL assert tile_valid on the next cycle (latency 1). data SHALL equal the window including that pixel, with tile_row=(row-3)/2 and tile_col=(col-3)/2.
REQ-019 Tile stride is 2 in both axes; tiles overlap by 2 rows and 2 columns; tiles per frame = (IMG_H/2-1)*(IMG_W/2-1), emitted in raster order of (i,j).
REQ-020 Cycles with pix_valid low SHALL hold all state; tile_valid and frame_done SHALL be 0 on the following cycle.
REQ-021 Window contents from the previous row (col<3) SHALL never be emitted, because emission requires col>=3.
REQ-022 frame_done SHALL assert on the cycle after the valid pixel at (IMG_H-1, IMG_W-1); that pixel also emits the last tile, so both pulses coincide.
REQ-023 data, tile_row and tile_col SHALL hold their last values while tile_valid is 0.
REQ-024 There is no backpressure; a consumer SHALL accept every tile on the tile_valid cycle.

Reset
REQ-025 When rstn=0 at a clock edge: row, col, tile_valid, frame_done, tile_row, tile_col and data SHALL become 0, and the window array SHALL be cleared; line-buffer contents need not be cleared.
REQ-026 Reset mid-frame SHALL abandon the frame; the first valid pixel after reset SHALL be treated as (0,0).
REQ-027 Outputs SHALL be 0 during reset and on the first cycle after release.

Verification (IMG_W=IMG_H=8, WI=8, pixel value = 8*row+col+1)
REQ-028 Continuous frame, pix_sof on the first pixel:
  - first tile_valid one cycle after pixel (3,3);
  - data = 128'h1C1B1A19_14131211_0C0B0A09_04030201;
  - tile_row=0, tile_col=0.
REQ-029 Same frame, second tile after pixel (3,5):
  - data = 128'h1E1D1C1B_16151413_0E0D0C0B_06050403;
  - tile_col=1.
REQ-030 Full frame tile count:
  - exactly 9 tile_valid pulses;
  - last tile has tile_row=2, tile_col=2, d[0][0]=0x25, d[3][3]=0x40;
  - frame_done is coincident with the last tile.
REQ-031 Same frame with pix_valid deasserted on random cycles (about 30 percent):
  - identical 9 tiles in identical order;
  - no tile_valid on any cycle following a pix_valid=0 cycle.
REQ-032 Reset and resync:
  - rstn=0 for 2 cycles after pixel (4,2), then a fresh frame;
  - first tile matches REQ-028 and 9 tiles are emitted;
  - separately, pix_sof asserted mid-frame restarts the count identically.
REQ-033 Back-to-back frames with no gap: the second frame's 9 tiles match the first frame's, and frame_done pulses once per frame.
